// File: rtl/seven_seg_scan_if.sv
// seven_seg_scan_if: BCD converter handshake and common-anode display signals.
interface seven_seg_scan_if;
  logic       ready;
  logic [3:0] A;
  logic [3:0] B;
  logic [3:0] C;
  logic [3:0] D;
  logic       start;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  modport master (output ready, A, B, C, D, input start, seg, dp, an);
  modport slave (input ready, A, B, C, D, output start, seg, dp, an);
endinterface

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: latches BCD conversions and scans them onto a 4-digit active-low display.
module seven_seg_scan #(
  parameter int PRESCALE          = 256,
  parameter int FRAMES_PER_UPDATE = 64,
  parameter bit BLANK_LEADING     = 1'b1
) (
  input logic             clk,
  input logic             rst,
  seven_seg_scan_if.slave bus
);
  localparam int PW = $clog2(PRESCALE);
  localparam int FW = FRAMES_PER_UPDATE > 1 ? $clog2(FRAMES_PER_UPDATE) : 1;
  logic [PW-1:0]     r_pre;
  logic [1:0]        r_idx;
  logic [FW-1:0]     r_frame;
  logic [3:0][3:0]   r_dig;
  logic              r_pend;
  logic              r_ready_d;
  logic              r_start;
  logic              r_booted;
  logic [6:0]        r_seg;
  logic [3:0]        r_an;
  logic              w_rise;
  logic              w_pre_wrap;
  logic              w_frame_end;
  logic              w_issue;
  logic              w_blank;
  logic [3:0]        w_cur;
  logic [6:0]        w_seg;
  assign w_rise      = bus.ready & ~r_ready_d;
  assign w_pre_wrap  = r_pre == PW'(PRESCALE - 1);
  assign w_frame_end = w_pre_wrap && r_idx == 2'd3 && r_frame == FW'(FRAMES_PER_UPDATE - 1);
  // r_booted is clear only until the first edge out of reset, which always requests a conversion
  assign w_issue     = !r_booted || (w_frame_end && !r_pend);
  assign w_cur       = r_dig[r_idx];
  assign w_blank     = BLANK_LEADING && (r_idx == 2'd3 ? r_dig[3] == 4'd0 :
                       r_idx == 2'd2 ? r_dig[3] == 4'd0 && r_dig[2] == 4'd0 :
                       r_idx == 2'd1 ? r_dig[3] == 4'd0 && r_dig[2] == 4'd0 && r_dig[1] == 4'd0 : 1'b0);
  assign bus.start   = r_start;
  assign bus.seg     = r_seg;
  assign bus.an      = r_an;
  assign bus.dp      = 1'b1;
  always_comb begin
    w_seg = 7'b0111111;
    case (w_cur)
      4'd0: w_seg = 7'b1000000;
      4'd1: w_seg = 7'b1111001;
      4'd2: w_seg = 7'b0100100;
      4'd3: w_seg = 7'b0110000;
      4'd4: w_seg = 7'b0011001;
      4'd5: w_seg = 7'b0010010;
      4'd6: w_seg = 7'b0000010;
      4'd7: w_seg = 7'b1111000;
      4'd8: w_seg = 7'b0000000;
      4'd9: w_seg = 7'b0010000;
      default: w_seg = 7'b0111111;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre     <= '0;
      r_idx     <= '0;
      r_frame   <= '0;
      r_dig     <= '0;
      r_pend    <= 1'b0;
      r_ready_d <= 1'b0;
      r_start   <= 1'b0;
      r_booted  <= 1'b0;
      r_seg     <= '1;
      r_an      <= '1;
    end else begin
      r_ready_d <= bus.ready;
      r_booted  <= 1'b1;
      r_start   <= w_issue;
      if (w_rise) r_dig <= {bus.A, bus.B, bus.C, bus.D};
      r_pend    <= w_issue ? 1'b1 : w_rise ? 1'b0 : r_pend;
      r_pre     <= w_pre_wrap ? '0 : r_pre + 1'b1;
      if (w_pre_wrap) begin
        r_idx <= r_idx + 1'b1;
        if (r_idx == 2'd3) r_frame <= r_frame == FW'(FRAMES_PER_UPDATE - 1) ? '0 : r_frame + 1'b1;
      end
      r_seg     <= w_blank ? '1 : w_seg;
      r_an      <= w_blank ? '1 : ~(4'b0001 << r_idx);
    end
  end
endmodule
